// File: rtl/board_pkg.sv
// Shared board geometry, cell type and row-server FSM states.
// Used by the row server, the colour mapper and the game logic.
package board_pkg;
    localparam int BOARD_COLS = 10;
    localparam int BOARD_ROWS = 20;
    localparam int CELL_W     = 16;
    localparam int ADDR_W     = 8;
    localparam int CELLS      = BOARD_ROWS * BOARD_COLS;

    typedef logic [CELL_W-1:0] cell_t;
    typedef logic [ADDR_W-1:0] addr_t;

    typedef enum logic [2:0] {CLEAR, IDLE, READ, DRAIN, COMMIT} state_t;

    function automatic addr_t cell_addr(input logic [7:0] row, input logic [3:0] col);
        return addr_t'(row * addr_t'(BOARD_COLS)) + addr_t'(col);
    endfunction
endpackage

// File: rtl/board_ram.sv
// Single-port board storage with synchronous read, one-cycle latency.
module board_ram
    import board_pkg::*;
(
    input  logic  clk_i,
    input  logic  we_i,
    input  addr_t addr_i,
    input  cell_t wdata_i,
    output cell_t rdata_o
);
    cell_t mem_q [CELLS];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end else begin
            rdata_o <= mem_q[addr_i];
        end
    end
endmodule

// File: rtl/board_row_server.sv
// Serves whole-row fetches of the board to the colour mapper and takes cell writes
// from game logic, which pre-empt fetch reads on the shared RAM port.
module board_row_server
    import board_pkg::*;
(
    input  logic       Clk,
    input  logic       reset,
    input  logic       LD_Row,
    input  logic [7:0] rowNum,
    input  logic       wr_en,
    input  logic [4:0] wr_row,
    input  logic [3:0] wr_col,
    input  cell_t      wr_data,
    output cell_t      Row [BOARD_COLS],
    output logic       rowReady,
    output logic       busy
);
    state_t     state_q;
    addr_t      clr_q;
    logic [3:0] col_q;
    logic [7:0] req_row_q;
    logic       pend_q;
    logic [7:0] pend_row_q;
    logic       ld_q;
    logic       rd_vld_q;
    logic [3:0] rd_col_q;
    cell_t      shadow_q [BOARD_COLS];
    cell_t      row_q [BOARD_COLS];
    logic       ready_q;

    logic       req;
    logic       wr_ok;
    logic       issue;
    logic [7:0] acc_row;
    logic       ram_we;
    addr_t      ram_addr;
    cell_t      ram_wdata;
    cell_t      ram_rdata;

    assign req     = LD_Row & ~ld_q;
    assign wr_ok   = wr_en && (state_q != CLEAR) && (int'(wr_row) < BOARD_ROWS)
                     && (int'(wr_col) < BOARD_COLS);
    assign issue   = (state_q == READ) && !wr_ok;
    assign acc_row = req ? rowNum : pend_row_q;

    always_comb begin
        ram_we    = 1'b0;
        ram_addr  = cell_addr(req_row_q, col_q);
        ram_wdata = '0;
        if (state_q == CLEAR) begin
            ram_we   = 1'b1;
            ram_addr = clr_q;
        end else if (wr_ok) begin
            ram_we    = 1'b1;
            ram_addr  = cell_addr({3'b000, wr_row}, wr_col);
            ram_wdata = wr_data;
        end
    end

    board_ram u_ram (
        .clk_i   (Clk),
        .we_i    (ram_we),
        .addr_i  (ram_addr),
        .wdata_i (ram_wdata),
        .rdata_o (ram_rdata)
    );

    always_ff @(posedge Clk) begin
        if (reset) begin
            state_q    <= CLEAR;
            clr_q      <= '0;
            col_q      <= '0;
            req_row_q  <= '0;
            pend_q     <= 1'b0;
            pend_row_q <= '0;
            ld_q       <= 1'b0;
            rd_vld_q   <= 1'b0;
            rd_col_q   <= '0;
            shadow_q   <= '{default: '0};
            row_q      <= '{default: '0};
            ready_q    <= 1'b0;
        end else begin
            ld_q     <= LD_Row;
            ready_q  <= 1'b0;
            rd_vld_q <= issue;
            rd_col_q <= col_q;
            if (rd_vld_q) begin
                shadow_q[rd_col_q] <= ram_rdata;
            end
            // One-deep slot; a newer request overwrites an older one.
            if (req && state_q != CLEAR && state_q != IDLE) begin
                pend_q     <= 1'b1;
                pend_row_q <= rowNum;
            end
            case (state_q)
                CLEAR: begin
                    if (clr_q == addr_t'(CELLS - 1)) begin
                        state_q <= IDLE;
                    end else begin
                        clr_q <= clr_q + 1'b1;
                    end
                end
                IDLE: begin
                    if (req || pend_q) begin
                        pend_q    <= 1'b0;
                        req_row_q <= acc_row;
                        if (int'(acc_row) >= BOARD_ROWS) begin
                            shadow_q <= '{default: '0};
                            row_q    <= '{default: '0};
                            ready_q  <= 1'b1;
                            state_q  <= COMMIT;
                        end else begin
                            col_q   <= '0;
                            state_q <= READ;
                        end
                    end
                end
                READ: begin
                    if (issue) begin
                        if (col_q == 4'(BOARD_COLS - 1)) begin
                            state_q <= DRAIN;
                        end else begin
                            col_q <= col_q + 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    // Last word bypasses the shadow so Row is complete on entering COMMIT.
                    row_q                 <= shadow_q;
                    row_q[BOARD_COLS - 1] <= ram_rdata;
                    ready_q               <= 1'b1;
                    state_q               <= COMMIT;
                end
                COMMIT: state_q <= IDLE;
                default: state_q <= CLEAR;
            endcase
        end
    end

    assign Row      = row_q;
    assign rowReady = ready_q;
    assign busy     = (state_q != IDLE);
endmodule

// File: tb/tb_board_row_server.sv
// Directed and randomized checks of board_row_server against a board-array model.
module tb_board_row_server;
    import board_pkg::*;

    logic       Clk;
    logic       reset;
    logic       LD_Row;
    logic [7:0] rowNum;
    logic       wr_en;
    logic [4:0] wr_row;
    logic [3:0] wr_col;
    cell_t      wr_data;
    cell_t      Row [BOARD_COLS];
    logic       rowReady;
    logic       busy;

    board_row_server dut (
        .Clk      (Clk),
        .reset    (reset),
        .LD_Row   (LD_Row),
        .rowNum   (rowNum),
        .wr_en    (wr_en),
        .wr_row   (wr_row),
        .wr_col   (wr_col),
        .wr_data  (wr_data),
        .Row      (Row),
        .rowReady (rowReady),
        .busy     (busy)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic [15:0] model [BOARD_ROWS][BOARD_COLS];

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;
    always @(posedge Clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [159:0] dut_row();
        logic [159:0] v;
        for (int c = 0; c < BOARD_COLS; c++) v[c*16 +: 16] = Row[c];
        return v;
    endfunction

    function automatic logic [159:0] exp_row(input int r);
        logic [159:0] v = '0;
        if (r < BOARD_ROWS) begin
            for (int c = 0; c < BOARD_COLS; c++) v[c*16 +: 16] = model[r][c];
        end
        return v;
    endfunction

    task automatic clear_model();
        for (int r = 0; r < BOARD_ROWS; r++)
            for (int c = 0; c < BOARD_COLS; c++) model[r][c] = '0;
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic model_write(input int r, input int c, input logic [15:0] d);
        if (r < BOARD_ROWS && c < BOARD_COLS) model[r][c] = d;
    endtask

    task automatic drive_write(input int r, input int c, input logic [15:0] d);
        wr_en   = 1'b1;
        wr_row  = 5'(r);
        wr_col  = 4'(c);
        wr_data = d;
        model_write(r, c, d);
    endtask

    task automatic do_write(input int r, input int c, input logic [15:0] d);
        drive_write(r, c, d);
        tick();
        wr_en = 1'b0;
    endtask

    // Presents a one-cycle rising edge; returns the acceptance cycle number.
    task automatic raise_ld(input int r, output int a0);
        LD_Row = 1'b1;
        rowNum = 8'(r);
        a0     = cyc;
        tick();
        LD_Row = 1'b0;
    endtask

    task automatic wait_ready(input int a0, input int lat, input int r, input string tag);
        int n = 0;
        @(negedge Clk);
        while (rowReady !== 1'b1 && n < 60) begin
            @(negedge Clk);
            n++;
        end
        chk({tag, "_lat"}, 160'(cyc - a0), 160'(lat));
        chk({tag, "_row"}, dut_row(), exp_row(r));
    endtask

    task automatic count_busy(output int n, output int pulses);
        n = 0;
        pulses = 0;
        @(negedge Clk);
        while (busy === 1'b1 && n < 300) begin
            if (rowReady === 1'b1) pulses++;
            n++;
            @(negedge Clk);
        end
    endtask

    task automatic count_pulses(input int cycles, output int pulses);
        pulses = 0;
        repeat (cycles) begin
            @(negedge Clk);
            if (rowReady === 1'b1) pulses++;
        end
    endtask

    initial begin
        int a0, a1, n, p, r, nw;
        reset   = 1'b1;
        LD_Row  = 1'b0;
        rowNum  = '0;
        wr_en   = 1'b0;
        wr_row  = '0;
        wr_col  = '0;
        wr_data = '0;
        clear_model();

        repeat (3) @(posedge Clk);
        @(negedge Clk);
        chk("rst_row", dut_row(), '0);
        chk("rst_ready", 160'(rowReady), 160'(0));
        chk("rst_busy", 160'(busy), 160'(1));
        @(posedge Clk);
        #1;
        reset = 1'b0;
        count_busy(n, p);
        chk("clear_len", 160'(n), 160'(200));
        tick();

        raise_ld(5, a0);
        wait_ready(a0, 12, 5, "fetch5_zero");
        tick();

        do_write(3, 4, 16'h0F00);
        do_write(3, 9, 16'h00F0);
        raise_ld(3, a0);
        wait_ready(a0, 12, 3, "fetch3");
        tick();

        raise_ld(22, a0);
        wait_ready(a0, 1, 22, "oor22");
        tick();

        // Two stalling writes during READ, both to cells not yet read.
        raise_ld(3, a0);
        tick();
        drive_write(3, 7, 16'h000F);
        tick();
        wr_en = 1'b0;
        tick();
        drive_write(3, 8, 16'h0123);
        tick();
        wr_en = 1'b0;
        wait_ready(a0, 14, 3, "stall2");
        tick();

        // Out-of-range write during READ is dropped and costs no stall.
        raise_ld(5, a0);
        tick();
        drive_write(25, 2, 16'hBEEF);
        tick();
        wr_en = 1'b0;
        wait_ready(a0, 12, 5, "oor_wr");
        tick();

        LD_Row = 1'b1;
        rowNum = 8'd3;
        count_pulses(30, p);
        chk("held_row", dut_row(), exp_row(3));
        tick();
        LD_Row = 1'b0;
        count_pulses(10, n);
        chk("held_pulses", 160'(p + n), 160'(1));
        tick();

        do_write(2, 0, 16'h0222);
        do_write(8, 5, 16'h0888);
        do_write(6, 1, 16'h0666);
        raise_ld(2, a0);
        tick();
        raise_ld(6, a1);
        tick();
        raise_ld(8, a1);
        wait_ready(a0, 12, 2, "pend_first");
        wait_ready(a0, 25, 8, "pend_latest");
        count_pulses(20, p);
        chk("pend_single", 160'(p), 160'(0));
        chk("row_hold", dut_row(), exp_row(8));
        tick();

        for (int i = 0; i < 8; i++) begin
            nw = $urandom_range(5, 0);
            for (int k = 0; k < nw; k++) begin
                do_write($urandom_range(23, 0), $urandom_range(11, 0),
                         16'($urandom_range(16'hFFF, 1)));
            end
            r = $urandom_range(23, 0);
            raise_ld(r, a0);
            wait_ready(a0, (r < BOARD_ROWS) ? 12 : 1, r, $sformatf("rand%0d_r%0d", i, r));
            tick();
        end

        // Reset mid-fetch with a pending request outstanding.
        raise_ld(3, a0);
        tick();
        raise_ld(6, a1);
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        clear_model();
        count_busy(n, p);
        chk("reclear_len", 160'(n), 160'(200));
        chk("reclear_pulses", 160'(p), 160'(0));
        chk("reclear_row", dut_row(), '0);
        count_pulses(30, p);
        chk("pend_dropped", 160'(p), 160'(0));
        tick();
        raise_ld(3, a0);
        wait_ready(a0, 12, 3, "after_reclear");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/board_row_server.md
Name: board_row_server

Overview:
- Owns the Tetris board storage: BOARD_ROWS x BOARD_COLS cells, each a 16-bit word. Bits [11:0] hold a 4:4:4 RGB colour; 0 means an empty cell.
- Serves the colour mapper's row-fetch protocol. The mapper raises LD_Row with rowNum, and this block reads that board row and presents it on Row[] with a one-cycle rowReady pulse.
- Also accepts single-cell writes from game logic on a port that has priority over fetch reads.
- Sits between the game/piece logic and the colour mapper.

Parameters:
- BOARD_COLS, 10, cells per row.
- BOARD_ROWS, 20, rows on the board.
- CELL_W, 16, bits per cell.
- ADDR_W, 8, storage address width (row*BOARD_COLS+col).

Ports:
- Clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- LD_Row  in  1  fetch request from colour mapper (level; may stay high for many cycles).
- rowNum  in  8  requested board row.
- wr_en  in  1  game-logic cell write strobe.
- wr_row  in  5  row of cell being written.
- wr_col  in  4  column of cell being written.
- wr_data  in  CELL_W  cell value to write.
- Row  out  BOARD_COLS x CELL_W  registered row image (unpacked array [BOARD_COLS]).
- rowReady  out  1  one-cycle pulse: Row has just been updated.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Storage: internal array of BOARD_ROWS*BOARD_COLS words, single port, synchronous read with 1-cycle latency. Exactly one access (read or write) per cycle.
- Reset values: Row all zero, rowReady 0, busy 1. FSM enters CLEAR. Pending flag and column counter are 0.
- CLEAR state:
  - Writes 0 to addresses 0..199, one per cycle: 200 cycles, then IDLE.
  - wr_en is ignored; requests are not accepted and are not queued.
- Request detection: a request is LD_Row=1 while LD_Row was 0 in the previous cycle (rising edge, registered). A level held for N cycles produces exactly one fetch.
- IDLE state, on request:
  - Latch rowNum as req_row.
  - If req_row >= BOARD_ROWS: go to COMMIT with the shadow forced to zero. Row becomes all zero and rowReady=1 in cycle A+1, where A is the acceptance cycle.
  - Otherwise go to READ with col=0.
- READ state:
  - Each cycle without wr_en: issue read of req_row*BOARD_COLS+col and increment col.
  - After col 9 is issued, go to DRAIN.
  - Returned data lands in shadow[col-1] one cycle after issue.
- Write priority:
  - wr_en=1 in any non-CLEAR state takes the port that cycle.
  - In READ, a write stalls the read: col holds and no data is captured the following cycle.
  - A write to a cell not yet read in the current fetch is visible in that fetch.
- DRAIN state: capture the final word into shadow[9], then COMMIT.
- COMMIT state:
  - Copy shadow to Row in one cycle (all cells at once), assert rowReady for that cycle, then go to IDLE.
  - Nominal in-range latency: A+12 (reads issued A+1..A+10, data A+2..A+11, commit A+12), plus 1 per write stall.
- Request while busy (not CLEAR): set pending and latch rowNum, latest wins, depth 1. On return to IDLE, the pending request is accepted immediately in that cycle.
- Write address out of range (wr_row >= BOARD_ROWS or wr_col >= BOARD_COLS): write dropped, no stall.
- Row holds its value between commits. rowReady is never high outside COMMIT.
- reset asserted mid-fetch: abort, restart CLEAR, Row zeroed, pending cleared.
- Address arithmetic: req_row*BOARD_COLS+col computed in ADDR_W bits; max 199, no overflow.

Decomposition:
- Package board_pkg:
  - BOARD_COLS, BOARD_ROWS, CELL_W constants.
  - cell_t typedef (logic [CELL_W-1:0]).
  - State enum {CLEAR, IDLE, READ, DRAIN, COMMIT}.
  - Shared by the colour mapper and game logic.
- One sub-module, board_ram: single-port sync-read RAM (addr, we, wdata, rdata), 1-cycle latency.
- The FSM, request edge detect, pending slot and shadow buffer stay in board_row_server.

Test Plan:
- Reset release -> busy=1 for exactly 200 cycles, then 0. A fetch of row 5 then returns all-zero Row with rowReady at A+12.
- Write 16'h0F00 to (3,4) and 16'h00F0 to (3,9), then LD_Row with rowNum=3 -> rowReady at A+12; Row[4]=0F00, Row[9]=00F0, all other cells 0.
- rowNum=22 -> no reads; rowReady at A+1 with Row all zero.
- Fetch row 3 with wr_en pulsed twice during READ (writing (3,7)=16'h000F before col 7 is read) -> rowReady at A+14; Row[7]=000F.
- LD_Row held high 30 cycles with rowNum=3 -> exactly one rowReady pulse.
- While fetching row 2, issue rising edges for row 6 then row 8 -> commit of row 2, then a single further fetch returning row 8. Assert reset at A+5 of a fetch -> no rowReady, Row zero, CLEAR restarts.
